// File: rtl/mem_stage_lsu_pkg.sv
// Shared types, funct3 codes and lane helpers for the MEM-stage load/store unit.
// XLEN is taken from the `XLEN macro and defaults to 32 when no build defines it.
`ifndef XLEN
`define XLEN 32
`endif

package mem_stage_lsu_pkg;

  localparam int XLEN   = `XLEN;
  localparam int RDW    = 5;
  localparam int NBYTES = XLEN / 8;

  localparam logic [2:0] LSU_F3_B  = 3'd0;
  localparam logic [2:0] LSU_F3_H  = 3'd1;
  localparam logic [2:0] LSU_F3_W  = 3'd2;
  localparam logic [2:0] LSU_F3_BU = 3'd4;
  localparam logic [2:0] LSU_F3_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic f3Valid(input logic [2:0] f3);
    return (f3 == LSU_F3_B) || (f3 == LSU_F3_H) || (f3 == LSU_F3_W) ||
           (f3 == LSU_F3_BU) || (f3 == LSU_F3_HU);
  endfunction

  // Only the size bits f3[1:0] matter for lanes, so unsigned codes alias B/H.
  function automatic logic [NBYTES-1:0] storeBe(input logic [2:0] f3, input logic [1:0] addr);
    logic [NBYTES-1:0] be;
    be = '0;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << addr;
      2'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XW = XLEN
) (
  input  logic [XW-1:0] rdata_i,
  input  logic [1:0]    addr_i,
  input  logic [2:0]    funct3_i,
  output logic [XW-1:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel  = rdata_i[{addr_i, 3'b000} +: 8];
    halfSel  = rdata_i[{addr_i[1], 4'b0000} +: 16];
    result_o = '0;
    case (funct3_i)
      LSU_F3_B:  result_o = {{(XW-8){byteSel[7]}}, byteSel};
      LSU_F3_BU: result_o = {{(XW-8){1'b0}}, byteSel};
      LSU_F3_H:  result_o = {{(XW-16){halfSel[15]}}, halfSel};
      LSU_F3_HU: result_o = {{(XW-16){1'b0}}, halfSel};
      LSU_F3_W:  result_o = rdata_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: registers ALU results toward WB and runs one req/gnt/rvalid
// data-memory transaction at a time. Define MISALIGN_TRAP_EN to trap misaligned H/W.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XW  = XLEN,
  parameter int RW  = RDW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XW-1:0]    ex_aluout,
  input  logic [XW-1:0]    ex_wdata,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_funct3,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XW-1:0]    dmem_addr,
  output logic [XW-1:0]    dmem_wdata,
  output logic [XW/8-1:0]  dmem_be,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XW-1:0]    dmem_rdata,
  output logic             wb_valid,
  output logic [RW-1:0]    wb_rd,
  output logic             wb_reg_write,
  output logic [XW-1:0]    wb_data,
  output logic             misalign
);

  lsu_state_e          state_q, state_d;
  logic [XW-1:0]       addr_q, addr_d;
  logic [XW-1:0]       sdata_q, sdata_d;
  logic [XW/8-1:0]     be_q, be_d;
  logic [2:0]          f3_q, f3_d;
  logic [RW-1:0]       rd_q, rd_d;
  logic                rw_q, rw_d;
  logic                we_q, we_d;
  logic                wbValid_q, wbValid_d;
  logic [RW-1:0]       wbRd_q, wbRd_d;
  logic                wbRw_q, wbRw_d;
  logic [XW-1:0]       wbData_q, wbData_d;
  logic                mis_q, mis_d;

  logic                accept, isMem, f3Ok, misAcc, launch;
  logic [XW-1:0]       loadData;

  assign ex_ready = (state_q == LSU_ST_IDLE) & ~rst;
  assign accept   = ex_valid & ex_ready;
  assign isMem    = ex_mem_read | ex_mem_write;
  assign f3Ok     = f3Valid(ex_funct3);

`ifdef MISALIGN_TRAP_EN
  assign misAcc = isMem & f3Ok &
                  (((ex_funct3[1:0] == 2'd1) & ex_aluout[0]) |
                   ((ex_funct3[1:0] == 2'd2) & (ex_aluout[1:0] != 2'b00)));
`else
  assign misAcc = 1'b0;
`endif

  assign launch = accept & isMem & f3Ok & ~misAcc;

  lsu_load_align #(.XW(XW)) u_align (
    .rdata_i  (dmem_rdata),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .result_o (loadData)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_ST_IDLE: if (launch) state_d = LSU_ST_REQ;
      LSU_ST_REQ:  if (dmem_gnt) state_d = we_q ? LSU_ST_IDLE : LSU_ST_WAIT;
      LSU_ST_WAIT: if (dmem_rvalid) state_d = LSU_ST_IDLE;
      default:     state_d = LSU_ST_IDLE;
    endcase
  end

  // The WB strobe defaults low each cycle so every result is a single-cycle pulse.
  always_comb begin
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    be_d      = be_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    we_d      = we_q;
    wbValid_d = 1'b0;
    wbRd_d    = wbRd_q;
    wbRw_d    = wbRw_q;
    wbData_d  = wbData_q;
    mis_d     = 1'b0;
    case (state_q)
      LSU_ST_IDLE: begin
        if (accept && !isMem) begin
          wbValid_d = 1'b1;
          wbData_d  = ex_aluout;
          wbRd_d    = ex_rd;
          wbRw_d    = ex_reg_write;
        end else if (accept && (!f3Ok || misAcc)) begin
          wbValid_d = 1'b1;
          wbData_d  = misAcc ? ex_aluout : '0;
          wbRd_d    = ex_rd;
          wbRw_d    = 1'b0;
          mis_d     = misAcc;
        end else if (launch) begin
          addr_d = ex_aluout;
          be_d   = storeBe(ex_funct3, ex_aluout[1:0]);
          f3_d   = ex_funct3;
          rd_d   = ex_rd;
          rw_d   = ex_reg_write;
          we_d   = ex_mem_write;
          case (ex_funct3[1:0])
            2'd0:    sdata_d = {(XW/8){ex_wdata[7:0]}};
            2'd1:    sdata_d = {(XW/16){ex_wdata[15:0]}};
            default: sdata_d = ex_wdata;
          endcase
        end
      end
      LSU_ST_REQ: begin
        if (dmem_gnt && we_q) begin
          wbValid_d = 1'b1;
          wbData_d  = '0;
          wbRd_d    = rd_q;
          wbRw_d    = 1'b0;
        end
      end
      LSU_ST_WAIT: begin
        if (dmem_rvalid) begin
          wbValid_d = 1'b1;
          wbData_d  = loadData;
          wbRd_d    = rd_q;
          wbRw_d    = rw_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      sdata_q   <= '0;
      be_q      <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      we_q      <= 1'b0;
      wbValid_q <= 1'b0;
      wbRd_q    <= '0;
      wbRw_q    <= 1'b0;
      wbData_q  <= '0;
      mis_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      be_q      <= be_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      we_q      <= we_d;
      wbValid_q <= wbValid_d;
      wbRd_q    <= wbRd_d;
      wbRw_q    <= wbRw_d;
      wbData_q  <= wbData_d;
      mis_q     <= mis_d;
    end
  end

  assign dmem_req     = (state_q == LSU_ST_REQ);
  assign dmem_we      = dmem_req & we_q;
  assign dmem_addr    = {addr_q[XW-1:2], 2'b00};
  assign dmem_wdata   = sdata_q;
  assign dmem_be      = dmem_req ? be_q : '0;
  assign wb_valid     = wbValid_q;
  assign wb_rd        = wbRd_q;
  assign wb_reg_write = wbRw_q;
  assign wb_data      = wbData_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
  logic unusedMis;
  assign unusedMis = mis_q;
`endif

endmodule
